// File: rtl/steer_en_gen.sv
// -----------------------------------------------------------------------------
// steer_en_gen
//
// Steering-enable controller. The rider is qualified from the left and right
// load-cell samples. The total weight has hysteresis. Before steering is
// enabled, the stance must stay balanced for a settle time. Steering is
// dropped if the rider leans too far to one side, or if the weight is lost.
//
// Parameters
//   LOAD_W        width of each load-cell sample
//   MIN_RIDER_WT  minimum lft+rght sum that qualifies a rider
//   WT_HYST       rider lost only when sum < MIN_RIDER_WT-WT_HYST
//   TMR_W         settle timer width
//   FAST_SIM      1: terminal count is the low 15 timer bits all ones
//   SETTLE_SHIFT  |diff| > sum>>SETTLE_SHIFT restarts the settle timer
//   STEER_SHIFT   |diff| > sum-(sum>>STEER_SHIFT) drops steering
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   lft_ld     left load-cell sample, unsigned
//   rght_ld    right load-cell sample, unsigned
//   ld_vld     one-clk strobe, lft_ld/rght_ld pair valid
//   en_steer   steering enabled (registered)
//   rider_off  no qualified rider (registered)
//   tmr_full   settle timer at terminal count (observe only)
// -----------------------------------------------------------------------------
module steer_en_gen #(
    parameter int                LOAD_W       = 12,
    parameter logic [LOAD_W-1:0] MIN_RIDER_WT = 12'h200,
    parameter logic [LOAD_W-1:0] WT_HYST      = 12'h040,
    parameter int                TMR_W        = 26,
    parameter int                FAST_SIM     = 0,
    parameter int                SETTLE_SHIFT = 2,
    parameter int                STEER_SHIFT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LOAD_W-1:0] lft_ld,
    input  logic [LOAD_W-1:0] rght_ld,
    input  logic              ld_vld,
    output logic              en_steer,
    output logic              rider_off,
    output logic              tmr_full
);

    // One extra bit keeps lft+rght and |lft-rght| free of overflow.
    localparam int SUM_W = LOAD_W + 1;

    localparam logic [SUM_W-1:0] WT_OK_THR   = {1'b0, MIN_RIDER_WT};
    localparam logic [SUM_W-1:0] WT_LOST_THR = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    // The terminal count covers only the low 15 bits in fast-simulation builds.
    localparam int FULL_W = (FAST_SIM != 0) ? 15 : TMR_W;

    localparam logic [TMR_W-1:0] TMR_ONE = {{(TMR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STEER
    } state_t;

    state_t             state_reg;
    logic [TMR_W-1:0]   timer_reg;
    logic               en_steer_reg;
    logic               rider_off_reg;

    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   abs_diff;
    logic [SUM_W-1:0]   settle_lim;
    logic [SUM_W-1:0]   use_lim;
    logic               wt_ok;
    logic               wt_lost;
    logic               diff_settle;
    logic               diff_use;

    assign sum = {1'b0, lft_ld} + {1'b0, rght_ld};

    // |lft - rght|. The larger operand is subtracted from, so the result is
    // never negative. The same value comes from negating a signed difference.
    assign abs_diff = (lft_ld >= rght_ld) ? ({1'b0, lft_ld}  - {1'b0, rght_ld})
                                          : ({1'b0, rght_ld} - {1'b0, lft_ld});

    assign settle_lim = sum >> SETTLE_SHIFT;
    assign use_lim    = sum - (sum >> STEER_SHIFT);

    assign wt_ok       = (sum >= WT_OK_THR);
    assign wt_lost     = (sum <  WT_LOST_THR);
    assign diff_settle = (abs_diff > settle_lim);
    assign diff_use    = (abs_diff > use_lim);

    // The timer stops counting at this value, so it is also the saturation
    // point.
    assign tmr_full = &timer_reg[FULL_W-1:0];

    // Single state machine. The outputs are registered and are loaded with
    // the decode of the state being entered. This keeps them in step with
    // state_reg, so en_steer and rider_off can never both be 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            en_steer_reg  <= 1'b0;
            rider_off_reg <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    // The hysteresis band is not enough to leave IDLE.
                    // Full weight is required.
                    if (ld_vld && wt_ok) begin
                        state_reg     <= WAIT;
                        timer_reg     <= '0;
                        en_steer_reg  <= 1'b0;
                        rider_off_reg <= 1'b0;
                    end
                end

                WAIT: begin
                    // A valid sample wins over the timer in the same cycle.
                    // Weight loss wins over the balance checks.
                    if (ld_vld && wt_lost) begin
                        state_reg     <= IDLE;
                        timer_reg     <= '0;
                        en_steer_reg  <= 1'b0;
                        rider_off_reg <= 1'b1;
                    end else if (ld_vld && diff_settle) begin
                        timer_reg <= '0;
                    end else if (tmr_full) begin
                        state_reg     <= STEER;
                        en_steer_reg  <= 1'b1;
                        rider_off_reg <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg + TMR_ONE;
                    end
                end

                STEER: begin
                    if (ld_vld && wt_lost) begin
                        state_reg     <= IDLE;
                        timer_reg     <= '0;
                        en_steer_reg  <= 1'b0;
                        rider_off_reg <= 1'b1;
                    end else if (ld_vld && diff_use) begin
                        state_reg     <= WAIT;
                        timer_reg     <= '0;
                        en_steer_reg  <= 1'b0;
                        rider_off_reg <= 1'b0;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    timer_reg     <= '0;
                    en_steer_reg  <= 1'b0;
                    rider_off_reg <= 1'b1;
                end
            endcase
        end
    end

    assign en_steer  = en_steer_reg;
    assign rider_off = rider_off_reg;

endmodule

// File: tb/tb_steer_en_gen.sv
// -----------------------------------------------------------------------------
// tb_steer_en_gen
//
// Testbench for steer_en_gen, built with FAST_SIM=1. The settle time is
// therefore 32768 clk.
//
// A new load sample is strobed every 1024 clk. For each strobe that a scenario
// checks, the expected outputs are placed on a queue. They are taken off the
// queue and compared on the first falling edge after the DUT has seen the
// strobe.
// -----------------------------------------------------------------------------
module tb_steer_en_gen;

    localparam int LOAD_W  = 12;
    localparam int STB_PER = 1024;
    localparam int SETTLE  = 32768;

    logic              clk;
    logic              rst_n;
    logic [LOAD_W-1:0] lft_ld;
    logic [LOAD_W-1:0] rght_ld;
    logic              ld_vld;
    logic              en_steer;
    logic              rider_off;
    logic              tmr_full;

    int errors = 0;
    int checks = 0;
    int phase  = 0;

    typedef struct {
        logic  en;
        logic  off;
        string tag;
    } exp_t;

    exp_t exp_q[$];

    steer_en_gen #(
        .LOAD_W       (LOAD_W),
        .MIN_RIDER_WT (12'h200),
        .WT_HYST      (12'h040),
        .TMR_W        (26),
        .FAST_SIM     (1),
        .SETTLE_SHIFT (2),
        .STEER_SHIFT  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .ld_vld    (ld_vld),
        .en_steer  (en_steer),
        .rider_off (rider_off),
        .tmr_full  (tmr_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checked on every cycle: the two status outputs must never both be 1.
    always @(negedge clk) begin
        checks++;
        if (en_steer === 1'b1 && rider_off === 1'b1) begin
            errors++;
            $display("FAIL safety t=%0t en_steer=%b rider_off=%b required not both 1",
                     $time, en_steer, rider_off);
        end
    end

    // Advance one clock. Inputs are driven at the falling edge, and a strobe
    // is issued whenever the phase counter wraps to zero.
    task automatic tick();
        @(negedge clk);
        ld_vld = (phase == 0);
        phase  = (phase == STB_PER - 1) ? 0 : phase + 1;
    endtask

    // Hold the current sample values, then check the outputs on every cycle
    // of the window.
    task automatic hold_check(input int n, input logic exp_en, input logic exp_off,
                              input string tag);
        int bad = 0;
        logic last_en = 1'b0;
        logic last_off = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (en_steer !== exp_en || rider_off !== exp_off) begin
                bad++;
                last_en  = en_steer;
                last_off = rider_off;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s bad_cycles=%0d en_steer=%b rider_off=%b required en=%b off=%b",
                     tag, bad, last_en, last_off, exp_en, exp_off);
        end else begin
            $display("hold %s cycles=%0d en=%b off=%b", tag, n, exp_en, exp_off);
        end
    endtask

    // Load the sample values and wait for the next strobe. The expected
    // outputs are queued, then compared one clock after the strobe edge.
    task automatic apply_sample(input logic [LOAD_W-1:0] l, input logic [LOAD_W-1:0] r,
                                input logic exp_en, input logic exp_off, input string tag);
        exp_t e;
        lft_ld  = l;
        rght_ld = r;
        while (phase != 0) tick();
        tick();
        exp_q.push_back('{en: exp_en, off: exp_off, tag: tag});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (en_steer !== e.en || rider_off !== e.off) begin
            errors++;
            $display("FAIL %s lft=%h rght=%h en_steer=%b rider_off=%b required en=%b off=%b",
                     e.tag, l, r, en_steer, rider_off, e.en, e.off);
        end else begin
            $display("sample %s lft=%h rght=%h en=%b off=%b", e.tag, l, r, en_steer, rider_off);
        end
    endtask

    // Start at the cycle after the strobe that entered WAIT, and count clocks
    // until en_steer rises. The count is bounded so that a stuck DUT fails.
    task automatic measure_settle(input string tag);
        int cnt = 0;
        int full_at = 0;
        logic off_seen = 1'b0;
        while (en_steer !== 1'b1 && cnt < SETTLE + 8192) begin
            tick();
            cnt++;
            if (tmr_full === 1'b1 && full_at == 0) full_at = cnt;
            if (rider_off !== 1'b0) off_seen = 1'b1;
        end
        checks++;
        if (cnt != SETTLE) begin
            errors++;
            $display("FAIL %s_rise clk_to_en=%0d required %0d", tag, cnt, SETTLE);
        end else begin
            $display("settle %s clk_to_en=%0d", tag, cnt);
        end
        checks++;
        if (full_at != SETTLE - 1) begin
            errors++;
            $display("FAIL %s_tmr_full first_full=%0d required %0d", tag, full_at, SETTLE - 1);
        end
        checks++;
        if (off_seen !== 1'b0) begin
            errors++;
            $display("FAIL %s_rider_off rider_off seen=%b required 0", tag, off_seen);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        ld_vld  = 1'b0;
        lft_ld  = '0;
        rght_ld = '0;
        repeat (4) @(negedge clk);
        checks++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1 || tmr_full !== 1'b0) begin
            errors++;
            $display("FAIL reset en=%b off=%b full=%b required 0/1/0",
                     en_steer, rider_off, tmr_full);
        end else begin
            $display("reset en=%b off=%b full=%b", en_steer, rider_off, tmr_full);
        end
        rst_n = 1'b1;
        phase = 0;
    endtask

    // The sum 0x150 is below the qualifying weight, so the controller stays
    // in IDLE.
    task automatic test_light_rider();
        apply_sample(12'h100, 12'h050, 1'b0, 1'b1, "light_rider");
        hold_check(2000, 1'b0, 1'b1, "light_rider_hold");
    endtask

    // Qualify the rider. At timer = 20000, assert reset between clock edges.
    // The outputs must reach their reset values with no clock edge.
    task automatic test_reset_mid_wait();
        apply_sample(12'h110, 12'h100, 1'b0, 1'b0, "qualify_pre_reset");
        hold_check(20000, 1'b0, 1'b0, "wait_20000");
        checks++;
        if (tmr_full !== 1'b0) begin
            errors++;
            $display("FAIL wait_tmr_full tmr_full=%b required 0", tmr_full);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (en_steer !== 1'b0 || rider_off !== 1'b1 || tmr_full !== 1'b0) begin
            errors++;
            $display("FAIL async_reset en=%b off=%b full=%b required 0/1/0",
                     en_steer, rider_off, tmr_full);
        end else begin
            $display("async_reset en=%b off=%b full=%b", en_steer, rider_off, tmr_full);
        end
        repeat (3) tick();
        ld_vld = 1'b0;
        rst_n  = 1'b1;
        phase  = 0;
    endtask

    // After the reset, a fresh qualification must take the whole settle
    // time.
    task automatic test_qualify();
        apply_sample(12'h110, 12'h100, 1'b0, 1'b0, "requalify");
        measure_settle("qualify");
    endtask

    // A sum of 0x1D0 is inside the hysteresis band. Steering stays enabled.
    task automatic test_hysteresis();
        apply_sample(12'h0E8, 12'h0E8, 1'b1, 1'b0, "hyst_sum_1d0");
    endtask

    // |diff| 0x1FC exceeds the in-use limit 0x1E4. Steering drops on the
    // first clock after the strobe, and the controller returns to WAIT.
    task automatic test_diff_drop();
        checks++;
        if (en_steer !== 1'b1) begin
            errors++;
            $display("FAIL pre_drop en_steer=%b required 1", en_steer);
        end
        apply_sample(12'h200, 12'h004, 1'b0, 1'b0, "diff_use_drop");
        checks++;
        if (tmr_full !== 1'b0) begin
            errors++;
            $display("FAIL drop_tmr_clear tmr_full=%b required 0", tmr_full);
        end
    endtask

    // |diff| 0xC0 exceeds the settle limit 0x90 and restarts the timer.
    // Without the restart, en_steer would rise 1024 clk earlier.
    task automatic test_settle_restart();
        apply_sample(12'h180, 12'h0C0, 1'b0, 1'b0, "settle_disturb");
        lft_ld  = 12'h110;
        rght_ld = 12'h100;
        measure_settle("restart");
    endtask

    // A sum of exactly 0x1C0 still holds the rider, and 0x1B0 drops to IDLE.
    // From IDLE, a sum in the hysteresis band is not enough to leave. A sum of
    // exactly 0x200 qualifies the rider again.
    task automatic test_weight_lost();
        apply_sample(12'h0E0, 12'h0E0, 1'b1, 1'b0, "lost_edge_1c0");
        apply_sample(12'h0D8, 12'h0D8, 1'b0, 1'b1, "lost_sum_1b0");
        apply_sample(12'h0FC, 12'h0FC, 1'b0, 1'b1, "idle_band_1f8");
        apply_sample(12'h100, 12'h100, 1'b0, 1'b0, "wt_ok_edge_200");
    endtask

    initial begin
        test_reset();
        test_light_rider();
        test_reset_mid_wait();
        test_qualify();
        test_hysteresis();
        test_diff_drop();
        test_settle_restart();
        test_weight_lost();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/steer_en_gen.md
Name: steer_en_gen

Overview:
- Parametrised steering-enable controller that replaces the fixed-threshold steering enable in the Segway digital core.
- Consumes left/right load-cell samples from the A2D interface and qualifies the rider by total weight, with hysteresis.
- Requires balanced stance (25% window) for a programmable settle time before asserting en_steer.
- Drops steering when imbalance exceeds the in-use window (15/16 of total) and flags rider_off to the power/auth logic.

Parameters:
LOAD_W, 12, width of each load-cell sample
MIN_RIDER_WT, 12'h200, minimum lft+rght sum that qualifies a rider
WT_HYST, 12'h040, hysteresis; rider lost only when sum < MIN_RIDER_WT-WT_HYST
TMR_W, 26, settle timer width; 2^26 clk ≈ 1.34 s at 50 MHz
FAST_SIM, 0, when 1, timer full = low 15 bits all ones (simulation speed-up)
SETTLE_SHIFT, 2, settle window: |diff| > sum>>SETTLE_SHIFT restarts timer (25%)
STEER_SHIFT, 4, in-use window: |diff| > sum-(sum>>STEER_SHIFT) drops steering (15/16)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
lft_ld  in  LOAD_W  left load-cell sample, unsigned
rght_ld  in  LOAD_W  right load-cell sample, unsigned
ld_vld  in  1  one-clk strobe, new lft_ld/rght_ld pair valid
en_steer  out  1  steering enabled, registered
rider_off  out  1  no qualified rider, registered
tmr_full  out  1  settle timer at terminal count (debug/observe)

Behaviour:
- Arithmetic: sum = lft_ld+rght_ld in LOAD_W+1 bits, no overflow. diff = lft_ld-rght_ld signed LOAD_W+1. abs_diff = |diff|.
- Comparisons: wt_ok = sum >= MIN_RIDER_WT. wt_lost = sum < MIN_RIDER_WT-WT_HYST. diff_settle = abs_diff > (sum>>SETTLE_SHIFT). diff_use = abs_diff > (sum - (sum>>STEER_SHIFT)). All comparisons unsigned and LOAD_W+1 wide.
- Sampling: comparisons act only in cycles where ld_vld=1. Between strobes, decisions hold.
- Timer: TMR_W-bit up counter.
  - Increments every clk in WAIT only.
  - Saturates at terminal count; never wraps.
  - Cleared on every entry to WAIT and on any clear event listed below.
  - tmr_full = all TMR_W bits set (FAST_SIM=0) or low 15 bits set (FAST_SIM=1).
- FSM states: IDLE, WAIT, STEER.
  - IDLE:
    - ld_vld & wt_ok -> WAIT, timer cleared.
    - Otherwise stay in IDLE.
  - WAIT:
    - ld_vld & wt_lost -> IDLE.
    - Else ld_vld & diff_settle -> stay in WAIT, timer cleared.
    - Else tmr_full -> STEER.
  - STEER:
    - ld_vld & wt_lost -> IDLE.
    - Else ld_vld & diff_use -> WAIT, timer cleared.
    - Otherwise stay in STEER.
- Priority:
  - ld_vld checks take precedence over tmr_full in the same cycle.
  - wt_lost takes precedence over any diff check.
- Hysteresis: a sum in [MIN_RIDER_WT-WT_HYST, MIN_RIDER_WT) keeps the current state in WAIT/STEER but does not leave IDLE.
- Outputs are registered from the next state:
  - en_steer=1 iff state==STEER.
  - rider_off=1 iff state==IDLE.
  - en_steer rises exactly 1 clk after the cycle in which tmr_full=1 and no disqualifying ld_vld is present.
  - en_steer falls 1 clk after the disqualifying ld_vld.
- Reset, asynchronous, any time including mid-count: state=IDLE, timer=0, en_steer=0, rider_off=1, tmr_full=0.
- Safety: en_steer and rider_off are never both 1.

Test Plan:
All scenarios use FAST_SIM=1 and ld_vld pulsed every 1024 clk.
1. Reset, then lft=12'h100, rght=12'h050 (sum 0x150 < 0x200) for 100k clk -> rider_off=1, en_steer=0 throughout.
2. lft=12'h110, rght=12'h100 -> WAIT; en_steer rises 32768 clk (±1 sample period) after first qualifying strobe; rider_off=0.
3. In STEER, apply lft=12'h200, rght=12'h004 (abs_diff 0x1FC > 0x1E4) -> en_steer=0 one clk after strobe; state WAIT; rider_off stays 0.
4. In WAIT, alternate balanced samples and a 12'h180/12'h0C0 sample (diff 0xC0 > sum/4 0x90) every 20k clk -> timer restarts; en_steer never asserts.
5. In STEER, sum drops to 0x1D0 (within hysteresis) -> en_steer stays 1. Sum then drops to 0x1B0 (< 0x1C0) -> IDLE, rider_off=1, en_steer=0.
6. Assert rst_n=0 asynchronously mid-WAIT at timer ≈ 20000 -> outputs immediately at reset values. After release, timer restarts from 0 and needs the full 32768 clk to reach STEER.
